// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage with req/ack memory port, prefetch
//               queue, valid/ready delivery and redirect flush.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_BUSY   = 2'd1;
    localparam logic [1:0] c_SQUASH = 2'd2;

    logic [1:0]         r_state;
    logic [31:0]        r_req_addr;
    logic [31:0]        r_fetch_pc;
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;
    logic [31:0]        r_mem_inst [DEPTH];
    logic [31:0]        r_mem_pc   [DEPTH];

    logic               w_push;
    logic               w_pop;
    logic [c_CNT_W-1:0] w_cnt_after;
    logic               w_space;
    logic               w_launch;
    logic [31:0]        w_tgt;

    assign imem_req   = (r_state != c_IDLE);
    assign imem_addr  = r_req_addr;
    assign inst_valid = (r_count != '0);
    // Head data is masked while empty so stale entries never leak out.
    assign inst       = inst_valid ? r_mem_inst[r_head] : 32'h0;
    assign inst_pc    = inst_valid ? r_mem_pc[r_head]   : 32'h0;

    assign w_push      = (r_state == c_BUSY) && imem_ack && !redirect;
    assign w_pop       = inst_valid && inst_ready;
    assign w_cnt_after = r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
    assign w_space     = (w_cnt_after < c_DEPTH_CNT);
    assign w_tgt       = redirect ? (redirect_pc & 32'hFFFF_FFFC) : r_fetch_pc;

    always_comb begin
        w_launch = 1'b0;
        case (r_state)
            c_IDLE:   w_launch = redirect || w_space;
            c_BUSY:   w_launch = imem_ack && (redirect || w_space);
            c_SQUASH: w_launch = imem_ack;
            default:  w_launch = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_req_addr <= RESET_PC;
            r_fetch_pc <= RESET_PC;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else begin
            if (w_launch) begin
                r_req_addr <= w_tgt;
                r_fetch_pc <= w_tgt + 32'd4;
            end else if (redirect) begin
                r_fetch_pc <= w_tgt;
            end

            if (redirect) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) r_tail <= r_tail + c_PTR_W'(1);
                if (w_pop)  r_head <= r_head + c_PTR_W'(1);
                r_count <= w_cnt_after;
            end

            case (r_state)
                c_IDLE: begin
                    if (w_launch) r_state <= c_BUSY;
                end
                c_BUSY: begin
                    if (imem_ack)      r_state <= w_launch ? c_BUSY : c_IDLE;
                    else if (redirect) r_state <= c_SQUASH;
                end
                c_SQUASH: begin
                    if (imem_ack) r_state <= c_BUSY;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Queue storage needs no reset: reads are masked by the count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_inst[r_tail] <= imem_rdata;
            r_mem_pc[r_tail]   <= r_req_addr;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit with a
//               variable-latency instruction memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    int errors = 0;
    int checks = 0;
    int lat    = 1;
    int w_cnt  = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_ready (inst_ready),
        .redirect   (redirect),
        .redirect_pc(redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    // Memory: acks on the lat-th cycle a request has been held high.
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (imem_req) begin
                if (w_cnt == lat - 1) begin
                    imem_ack   = 1'b1;
                    imem_rdata = word_at(imem_addr);
                    w_cnt      = 0;
                end else begin
                    imem_ack = 1'b0;
                    w_cnt    = w_cnt + 1;
                end
            end else begin
                imem_ack = 1'b0;
                w_cnt    = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        inst_ready  = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        lat         = 1;
        step();
        check("rst_req",   32'(imem_req),   32'h0);
        check("rst_addr",  imem_addr,       32'h0);
        check("rst_valid", 32'(inst_valid), 32'h0);
        check("rst_inst",  inst,            32'h0);
        check("rst_pc",    inst_pc,         32'h0);
        step();
        rst = 1'b0;

        // Zero-wait streaming, one instruction per cycle
        step();
        check("zw_req1",   32'(imem_req),   32'h1);
        check("zw_addr1",  imem_addr,       32'h0);
        check("zw_valid1", 32'(inst_valid), 32'h0);
        step();
        check("zw_addr2",  imem_addr,       32'h4);
        check("zw_valid2", 32'(inst_valid), 32'h1);
        check("zw_pc2",    inst_pc,         32'h0);
        check("zw_inst2",  inst,            32'hDEAD_0000);
        step();
        check("zw_addr3",  imem_addr,       32'h8);
        check("zw_pc3",    inst_pc,         32'h4);
        step();
        check("zw_addr4",  imem_addr,       32'hC);
        check("zw_pc4",    inst_pc,         32'h8);
        check("zw_inst4",  inst,            32'hDEAD_0008);

        // Reset with a request outstanding and a non-empty queue
        rst = 1'b1;
        #1;
        check("mid_rst_req",   32'(imem_req),   32'h0);
        check("mid_rst_addr",  imem_addr,       32'h0);
        check("mid_rst_valid", 32'(inst_valid), 32'h0);
        check("mid_rst_inst",  inst,            32'h0);
        check("mid_rst_pc",    inst_pc,         32'h0);
        inst_ready = 1'b0;
        step();
        rst = 1'b0;

        // Fill the queue with the consumer stalled
        step();
        check("full_first_addr", imem_addr, 32'h0);
        step(); step(); step(); step();
        check("full_req_low", 32'(imem_req),   32'h0);
        check("full_valid",   32'(inst_valid), 32'h1);
        check("full_head",    inst_pc,         32'h0);
        step(); step();
        check("full_still_idle", 32'(imem_req), 32'h0);
        check("full_hold_pc",    inst_pc,       32'h0);
        check("full_hold_inst",  inst,          32'hDEAD_0000);
        inst_ready = 1'b1;
        step();
        check("resume_req",  32'(imem_req), 32'h1);
        check("resume_addr", imem_addr,     32'h10);
        check("resume_pc4",  inst_pc,       32'h4);
        step();
        check("resume_pc8",  inst_pc,       32'h8);
        check("resume_addr2", imem_addr,    32'h14);
        step();
        check("resume_pcC",  inst_pc,       32'hC);
        step();
        check("resume_pc10",   inst_pc, 32'h10);
        check("resume_inst10", inst,    32'hDEAD_0010);

        // Slow memory, redirect during the second wait cycle
        rst = 1'b1;
        lat = 3;
        step(); step();
        rst = 1'b0;
        step();
        check("slow_addr0", imem_addr, 32'h0);
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0102;
        step();
        redirect = 1'b0;
        check("slow_addr_held", imem_addr,       32'h0);
        check("slow_req_held",  32'(imem_req),   32'h1);
        check("slow_sq_valid",  32'(inst_valid), 32'h0);
        step();
        check("slow_new_addr",  imem_addr,       32'h100);
        check("slow_no_stale",  32'(inst_valid), 32'h0);
        step(); step();
        check("slow_wait_valid", 32'(inst_valid), 32'h0);
        step();
        check("slow_valid", 32'(inst_valid), 32'h1);
        check("slow_pc",    inst_pc,         32'h100);
        check("slow_inst",  inst,            32'hDEAD_0100);
        check("slow_next",  imem_addr,       32'h104);

        // Redirect on the ack cycle of PC 0x8, queue holding 0x0 and 0x4
        rst        = 1'b1;
        lat        = 1;
        inst_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        step(); step(); step();
        check("ra_head",  inst_pc,   32'h0);
        check("ra_addr8", imem_addr, 32'h8);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0080;
        step();
        redirect = 1'b0;
        check("ra_flush_valid", 32'(inst_valid), 32'h0);
        check("ra_new_addr",    imem_addr,       32'h80);
        step();
        check("ra_valid", 32'(inst_valid), 32'h1);
        check("ra_pc80",  inst_pc,         32'h80);
        inst_ready = 1'b1;
        step();
        check("ra_pc84", inst_pc, 32'h84);

        // Two redirects during one outstanding slow request
        rst = 1'b1;
        lat = 4;
        step(); step();
        rst = 1'b0;
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        step();
        redirect_pc = 32'h0000_0300;
        step();
        redirect = 1'b0;
        step();
        check("dr_addr_held", imem_addr,       32'h0);
        check("dr_valid0",    32'(inst_valid), 32'h0);
        step();
        check("dr_addr300", imem_addr,       32'h300);
        check("dr_valid1",  32'(inst_valid), 32'h0);
        step(); step(); step();
        check("dr_valid2", 32'(inst_valid), 32'h0);
        step();
        check("dr_valid3", 32'(inst_valid), 32'h1);
        check("dr_pc",     inst_pc,         32'h300);
        check("dr_inst",   inst,            32'hDEAD_0300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
